// File: rtl/uart_rx_ctrl_if.sv
// Byte delivery handshake between the UART receiver and its consumer.
// The receiver drives data/valid; the consumer drives ready.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: two-flop line synchroniser, bit-centre sample timing,
// frame FSM (start check, LSB-first data shift, stop check, break wait) and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx_ctrl #(
  parameter int CLOCK_FREQ = 400,
  parameter int BAUD_RATE  = 100,
  parameter int DATA_BITS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rx,
  uart_rx_ctrl_if.master    data_if,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_INDEX   = (CYCLES_PER_BIT - 1) >> 1;
  localparam int CW             = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BW             = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CYC_LAST   = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_SAMPLE = CW'(SAMPLE_INDEX);
  // Start detect is cyc 0; the following cycle is cyc 1, which wraps to 0 when CPB==1.
  localparam logic [CW-1:0] CYC_AFTER_START = (CYCLES_PER_BIT == 1) ? '0 : CW'(1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

  if (CYCLES_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_rx_ctrl: CLOCK_FREQ/BAUD_RATE must be >= 1");
  end
  if (DATA_BITS < 1 || DATA_BITS > 8) begin : g_bad_bits
    $error("uart_rx_ctrl: DATA_BITS must be 1..8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BRK
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cyc;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] sr;

  logic                 sample;
  logic [CW-1:0]        cyc_inc;
  logic [DATA_BITS-1:0] sr_next;

  assign sample  = (cyc == CYC_SAMPLE);
  assign cyc_inc = (cyc == CYC_LAST) ? '0 : cyc + CW'(1);
  // LSB-first: each new bit enters at the top and walks down to bit 0.
  assign sr_next = (sr >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
  // Pure decode of the state register.
  assign busy    = (state != S_IDLE);

  // Two-flop synchroniser; idle-high reset so release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM plus holding register and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      cyc               <= '0;
      bit_cnt           <= '0;
      sr                <= '0;
      data_if.out_data  <= '0;
      data_if.out_valid <= 1'b0;
      frame_err         <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Drain; a byte loaded below on the same edge overrides this.
      if (data_if.out_valid && data_if.out_ready) data_if.out_valid <= 1'b0;

      if (!enable) begin
        state   <= S_IDLE;
        cyc     <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              cyc   <= CYC_AFTER_START;
              state <= (SAMPLE_INDEX == 0) ? S_DATA : S_START;
            end
          end
          S_START: begin
            cyc <= cyc_inc;
            if (sample) begin
              if (rx_s) begin
                state <= S_IDLE;
                cyc   <= '0;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            cyc <= cyc_inc;
            if (sample) begin
              sr <= sr_next;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= S_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
          S_STOP: begin
            cyc <= cyc_inc;
            if (sample) begin
              cyc <= '0;
              if (rx_s) begin
                state <= S_IDLE;
                if (!data_if.out_valid || data_if.out_ready) begin
                  data_if.out_data  <= sr;
                  data_if.out_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= S_BRK;
              end
            end
          end
          S_BRK: begin
            // Line held low after a bad stop: wait for idle before re-arming.
            if (rx_s) state <= S_IDLE;
          end
          default: begin
            state   <= S_IDLE;
            cyc     <= '0;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus a randomized stream, checked
// against an expected-byte queue and expected pulse counts.
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b1;
  logic rx = 1'b1;
  logic rx1 = 1'b1;
  logic ready = 1'b1;
  logic busy, frame_err, overrun;
  logic busy1, frame_err1, overrun1;

  uart_rx_ctrl_if #(.DATA_BITS(8)) bif ();
  uart_rx_ctrl_if #(.DATA_BITS(8)) bif1 ();
  assign bif.out_ready  = ready;
  assign bif1.out_ready = 1'b1;

  always #5 clk = ~clk;

  // 4 cycles per bit
  uart_rx_ctrl #(.CLOCK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx(rx), .data_if(bif),
    .busy(busy), .frame_err(frame_err), .overrun(overrun));

  // 1 cycle per bit
  uart_rx_ctrl #(.CLOCK_FREQ(100), .BAUD_RATE(100), .DATA_BITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .rx(rx1), .data_if(bif1),
    .busy(busy1), .frame_err(frame_err1), .overrun(overrun1));

  int checks = 0;
  int errors = 0;
  int n_busy = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0, n_ferr1 = 0;
  logic [7:0] got_q[$];
  logic [7:0] got1_q[$];
  logic [7:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int b_busy, b_v, b_f, b_o, b_g, b_g1, b_f1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_busy = n_busy; b_v = n_vcyc; b_f = n_ferr; b_o = n_ovr;
    b_g = got_q.size(); b_g1 = got1_q.size(); b_f1 = n_ferr1;
  endtask

  // Drive one frame: start, 8 data LSB-first, stop bit held stop_bits bit-times.
  // ready_at: cycle index at which to raise ready for one cycle (-1 none).
  // abort_at: cycle index at which to drop enable and end the frame (-1 none).
  task automatic send(input int sel, input logic [7:0] b, input logic stop,
                      input int stop_bits, input int ready_at, input int abort_at);
    int   cpb;
    int   k;
    logic v;
    cpb = (sel != 0) ? 1 : 4;
    for (int c = 0; c < (9 + stop_bits) * cpb; c++) begin
      k = c / cpb;
      if (k == 0) v = 1'b0;
      else if (k <= 8) v = b[k-1];
      else v = stop;
      if (c == abort_at) begin
        chk("abort_busy_pre", 32'(busy), 1);
        enable = 1'b0;
        rx = 1'b1;
        tick(1);
        return;
      end
      if (sel != 0) rx1 = v; else rx = v;
      if (c == ready_at) ready = 1'b1;
      tick(1);
    end
    if (ready_at >= 0) ready = 1'b0;
    if (sel != 0) rx1 = 1'b1; else rx = 1'b1;
  endtask

  // Observer for the CPB=4 instance: pulse counts, accepted bytes, hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(bif.out_valid), 1);
        chk("hold_data", 32'(bif.out_data), 32'(prev_data));
      end
      if (busy) n_busy++;
      if (bif.out_valid) n_vcyc++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (bif.out_valid && bif.out_ready) got_q.push_back(bif.out_data);
      prev_hold = bif.out_valid && !bif.out_ready;
      prev_data = bif.out_data;
    end
  end

  // Observer for the CPB=1 instance (always ready).
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif1.out_valid) got1_q.push_back(bif1.out_data);
      if (frame_err1) n_ferr1++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    int         r, sb, nexp_f;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", 32'(bif.out_data), 0);
    chk("rst_valid", 32'(bif.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Nominal 0xA5
    snap();
    send(0, 8'hA5, 1'b1, 1, -1, -1);
    tick(6);
    chk("nom_cnt", got_q.size() - b_g, 1);
    if (got_q.size() > b_g) chk("nom_data", 32'(got_q[b_g]), 32'hA5);
    chk("nom_vcyc", n_vcyc - b_v, 1);
    chk("nom_busy", n_busy - b_busy, 37);
    chk("nom_ferr", n_ferr - b_f, 0);
    chk("nom_ovr", n_ovr - b_o, 0);

    // One-cycle glitch
    snap();
    rx = 1'b0; tick(1); rx = 1'b1; tick(10);
    chk("glitch_busy", n_busy - b_busy, 1);
    chk("glitch_vcyc", n_vcyc - b_v, 0);
    chk("glitch_ferr", n_ferr - b_f, 0);

    // Framing error, line held low 10 bit-times, then 0x55
    snap();
    send(0, 8'h3C, 1'b0, 10, -1, -1);
    chk("brk_busy", 32'(busy), 1);
    tick(8);
    chk("ferr_cnt", n_ferr - b_f, 1);
    chk("ferr_vcyc", n_vcyc - b_v, 0);
    chk("brk_idle", 32'(busy), 0);
    send(0, 8'h55, 1'b1, 1, -1, -1);
    tick(6);
    chk("post_ferr_cnt", got_q.size() - b_g, 1);
    if (got_q.size() > b_g) chk("post_ferr_data", 32'(got_q[b_g]), 32'h55);

    // Overrun: 0x11 then 0x22 with no consumer
    ready = 1'b0;
    snap();
    send(0, 8'h11, 1'b1, 1, -1, -1);
    send(0, 8'h22, 1'b1, 1, -1, -1);
    tick(4);
    chk("ovr_cnt", n_ovr - b_o, 1);
    chk("ovr_data", 32'(bif.out_data), 32'h11);
    chk("ovr_valid", 32'(bif.out_valid), 1);
    ready = 1'b1;
    tick(1);
    chk("ovr_drain_valid", 32'(bif.out_valid), 0);
    chk("ovr_drain_cnt", got_q.size() - b_g, 1);
    if (got_q.size() > b_g) chk("ovr_drain_data", 32'(got_q[b_g]), 32'h11);

    // Simultaneous accept and load on the stop-sample edge of 0x22
    ready = 1'b0;
    snap();
    send(0, 8'h11, 1'b1, 1, -1, -1);
    tick(2);
    send(0, 8'h22, 1'b1, 1, 39, -1);
    tick(2);
    chk("sim_data", 32'(bif.out_data), 32'h22);
    chk("sim_valid", 32'(bif.out_valid), 1);
    chk("sim_ovr", n_ovr - b_o, 0);
    chk("sim_acc_cnt", got_q.size() - b_g, 1);
    if (got_q.size() > b_g) chk("sim_acc_data", 32'(got_q[b_g]), 32'h11);
    ready = 1'b1;
    tick(2);
    chk("sim_drain_cnt", got_q.size() - b_g, 2);
    if (got_q.size() > b_g + 1) chk("sim_drain_data", 32'(got_q[b_g+1]), 32'h22);

    // Enable abort after 3 data bits, then 0x7E
    snap();
    send(0, 8'hFF, 1'b1, 1, -1, 19);
    chk("abort_idle", 32'(busy), 0);
    tick(4);
    enable = 1'b1;
    tick(4);
    chk("abort_vcyc", n_vcyc - b_v, 0);
    chk("abort_ferr", n_ferr - b_f, 0);
    send(0, 8'h7E, 1'b1, 1, -1, -1);
    tick(6);
    chk("abort_next_cnt", got_q.size() - b_g, 1);
    if (got_q.size() > b_g) chk("abort_next_data", 32'(got_q[b_g]), 32'h7E);

    // Asynchronous reset mid-frame with a byte pending
    ready = 1'b0;
    send(0, 8'hC3, 1'b1, 1, -1, -1);
    tick(2);
    rx = 1'b0;
    tick(12);
    chk("mrst_pre_valid", 32'(bif.out_valid), 1);
    chk("mrst_pre_busy", 32'(busy), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_data", 32'(bif.out_data), 0);
    chk("mrst_valid", 32'(bif.out_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    rx = 1'b1;
    ready = 1'b1;
    tick(4);

    // Randomized stream, consumer always ready
    snap();
    nexp_f = 0;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rx = 1'b0; tick(1); rx = 1'b1; tick(4);
      end else begin
        rb = 8'($urandom);
        if (r == 1) begin
          sb = $urandom_range(1, 3);
          send(0, rb, 1'b0, sb, -1, -1);
          nexp_f++;
          tick(1 + $urandom_range(0, 4));
        end else begin
          send(0, rb, 1'b1, 1, -1, -1);
          exp_q.push_back(rb);
          tick($urandom_range(0, 4));
        end
      end
    end
    tick(10);
    chk("rand_cnt", got_q.size() - b_g, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (b_g + i < got_q.size()) chk("rand_data", 32'(got_q[b_g+i]), 32'(exp_q[i]));
    chk("rand_ferr", n_ferr - b_f, nexp_f);
    chk("rand_ovr", n_ovr - b_o, 0);

    // One cycle per bit
    snap();
    send(1, 8'hA5, 1'b1, 1, -1, -1);
    tick(6);
    chk("cpb1_cnt", got1_q.size() - b_g1, 1);
    if (got1_q.size() > b_g1) chk("cpb1_data", 32'(got1_q[b_g1]), 32'hA5);
    exp_q.delete();
    snap();
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      send(1, rb, 1'b1, 1, -1, -1);
      exp_q.push_back(rb);
    end
    send(1, 8'h0F, 1'b0, 2, -1, -1);
    tick(6);
    chk("cpb1_rand_cnt", got1_q.size() - b_g1, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (b_g1 + i < got1_q.size()) chk("cpb1_rand_data", 32'(got1_q[b_g1+i]), 32'(exp_q[i]));
    chk("cpb1_ferr", n_ferr1 - b_f1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
